// File: rtl/spi_slave_regbank_pkg.sv
// Shared definitions for the SPI responder register bank: frame geometry, FSM states, command byte layout.
// Optional build macro used by the top: SPI_FRAME_ERR_EN.
package spi_slave_regbank_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_RW_BIT     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
  } spi_cmd_t;

  function automatic logic addr_ok(input logic [6:0] addr, input int num_regs);
    return int'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin with single-cycle rise/fall strobes on the synced level.
// RST_VAL should match the pin's idle level so reset release does not fake an edge.
module spi_in_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic n_reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync_q <= {2{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[0], din};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;
  assign fall = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_slave_regbank.sv
// Mode-0 SPI responder terminating {rw,addr} + data frames in a local register bank, oversampled on clock.
// Define SPI_FRAME_ERR_EN to report frames aborted mid-way on frame_err/err_cnt.
module spi_slave_regbank
  import spi_slave_regbank_pkg::*;
#(
  parameter int         NUM_REGS = 32,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [6:0] loc_addr,
  output logic [7:0] loc_rdata,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam logic [4:0] CMD_LAST_BIT  = 5'(SPI_RW_BIT);
  localparam logic [4:0] DATA_LAST_BIT = 5'(SPI_FRAME_BITS - 1);

  logic       ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic [1:0] mosi_q;
  logic       mosi_s;

  spi_state_t state_q, state_d;
  logic [4:0] bit_cnt_q;
  logic [7:0] rx_q, tx_q, rx_next, cmd_rdata;
  spi_cmd_t   cmd_q;
  logic       miso_q, commit_q;
  logic       wr_valid_q;
  logic [6:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] bank [NUM_REGS];

  logic frame_start, rx_shift, tx_shift, cmd_last, data_last;

  spi_in_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clock   (clock),
    .n_reset (n_reset),
    .din     (ss),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  spi_in_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clock   (clock),
    .n_reset (n_reset),
    .din     (sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) mosi_q <= 2'b00;
    else          mosi_q <= {mosi_q[0], mosi};
  end
  assign mosi_s = mosi_q[1];

  function automatic logic [7:0] bank_rd(input logic [6:0] addr);
    logic [7:0] val;
    val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == 7'(i)) val = bank[i];
    end
    return val;
  endfunction

  assign rx_next   = {rx_q[6:0], mosi_s};
  assign cmd_rdata = bank_rd(rx_next[6:0]);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ss_fall) state_d = CMD;
        CMD:     if (sclk_rise && bit_cnt_q == CMD_LAST_BIT) state_d = DATA;
        DATA:    if (sclk_rise && bit_cnt_q == DATA_LAST_BIT) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A deselect wins over any edge seen in the same cycle.
  always_comb begin
    frame_start = 1'b0;
    rx_shift    = 1'b0;
    tx_shift    = 1'b0;
    cmd_last    = 1'b0;
    data_last   = 1'b0;
    if (!ss_rise) begin
      case (state_q)
        IDLE: frame_start = ss_fall;
        CMD: begin
          rx_shift = sclk_rise;
          cmd_last = sclk_rise && (bit_cnt_q == CMD_LAST_BIT);
        end
        DATA: begin
          rx_shift  = sclk_rise;
          tx_shift  = sclk_fall;
          data_last = sclk_rise && (bit_cnt_q == DATA_LAST_BIT);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      bit_cnt_q  <= 5'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      cmd_q      <= '0;
      miso_q     <= 1'b0;
      commit_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 7'h00;
      wr_data_q  <= 8'h00;
    end else begin
      wr_valid_q <= commit_q;
      commit_q   <= 1'b0;
      if (commit_q) begin
        wr_addr_q <= cmd_q.addr;
        wr_data_q <= rx_q;
      end
      if (ss_rise) begin
        bit_cnt_q <= 5'd0;
        tx_q      <= 8'h00;
        miso_q    <= 1'b0;
      end
      if (frame_start) begin
        bit_cnt_q <= 5'd0;
        rx_q      <= 8'h00;
        tx_q      <= 8'h00;
        miso_q    <= 1'b0;
      end
      if (rx_shift) begin
        rx_q      <= rx_next;
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
      if (cmd_last) begin
        cmd_q <= spi_cmd_t'(rx_next);
        tx_q  <= rx_next[SPI_RW_BIT] ? cmd_rdata : 8'h00;
      end
      if (tx_shift) begin
        miso_q <= tx_q[7];
        tx_q   <= {tx_q[6:0], 1'b0};
      end
      // Commit is deferred one cycle so rx_q already holds the full data byte.
      if (data_last) begin
        miso_q   <= 1'b0;
        commit_q <= !cmd_q.rw && addr_ok(cmd_q.addr, NUM_REGS);
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_valid_q && wr_addr_q == 7'(i)) bank[i] <= wr_data_q;
      end
    end
  end

  assign miso      = miso_q & ~ss;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign loc_rdata = bank_rd(loc_addr);

`ifdef SPI_FRAME_ERR_EN
  logic       abort;
  logic       frame_err_q;
  logic [7:0] err_cnt_q;

  assign abort = ss_rise && (state_q == CMD || state_q == DATA) && (bit_cnt_q != 5'd0);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      frame_err_q <= abort;
      if (abort && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_err = 1'b0;
  assign err_cnt   = 8'h00;
`endif

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Bench for spi_slave_regbank: a bit-banged mode-0 master, a frame-level bank model and a per-cycle compare process.
module tb_spi_slave_regbank;

  localparam int NUM_REGS = 32;
  localparam int HALF     = 5;
`ifdef SPI_FRAME_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic       ss = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [6:0] loc_addr = 7'h00;
  logic       miso, wr_valid, frame_err;
  logic [6:0] wr_addr;
  logic [7:0] wr_data, loc_rdata, err_cnt;

  spi_slave_regbank #(.NUM_REGS(NUM_REGS), .RST_VAL(8'h00)) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .ss        (ss),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .loc_addr  (loc_addr),
    .loc_rdata (loc_rdata),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model [128];
  int         wr_pulses = 0;
  int         fe_pulses = 0;
  int         exp_err = 0;
  bit         chk_loc = 1'b0;
  bit         chk_done = 1'b0;
  logic [6:0] exp_wr_addr = 7'h00;
  logic [7:0] exp_wr_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_loc(input logic [6:0] a);
    return (int'(a) < NUM_REGS) ? model[a] : 8'h00;
  endfunction

  always @(negedge clock) begin
    if (n_reset) begin
      if (ss) check("miso_deselected", 32'(miso), 32'h0);
      if (chk_done) check("miso_done", 32'(miso), 32'h0);
      if (chk_loc) begin
        check("loc_rdata", 32'(loc_rdata), 32'(exp_loc(loc_addr)));
        check("err_cnt", 32'(err_cnt), 32'(exp_err));
        check("wr_valid_quiet", 32'(wr_valid), 32'h0);
      end
      if (wr_valid) begin
        wr_pulses++;
        check("wr_addr_pulse", 32'(wr_addr), 32'(exp_wr_addr));
        check("wr_data_pulse", 32'(wr_data), 32'(exp_wr_data));
      end
      if (frame_err) fe_pulses++;
    end
  end

  task automatic clk_bit(input logic b, output logic s);
    mosi = b;
    repeat (HALF) @(negedge clock);
    s = miso;
    sclk = 1'b1;
    repeat (HALF) @(negedge clock);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                       input int extra, output logic [7:0] rd);
    logic [15:0] w;
    logic        s;
    int          p0, f0;
    bit          commit, abort;
    w      = {b0, b1};
    rd     = 8'h00;
    chk_loc = 1'b0;
    p0     = wr_pulses;
    f0     = fe_pulses;
    commit = (nbits >= 16) && !b0[7] && (int'(b0[6:0]) < NUM_REGS);
    abort  = (nbits > 0) && (nbits < 16);
    if (commit) begin
      exp_wr_addr = b0[6:0];
      exp_wr_data = b1;
    end
    @(negedge clock);
    ss = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      clk_bit(w[15-i], s);
      if (i >= 8) rd = {rd[6:0], s};
    end
    if (nbits >= 16) begin
      repeat (HALF) @(negedge clock);
      chk_done = 1'b1;
      for (int e = 0; e < extra; e++) clk_bit(e[0], s);
    end
    repeat (2) @(negedge clock);
    chk_done = 1'b0;
    ss   = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clock);
    if (commit) model[b0[6:0]] = b1;
    if (abort && ERR_EN == 1 && exp_err < 255) exp_err++;
    check("wr_pulses_per_frame", 32'(wr_pulses - p0), commit ? 32'h1 : 32'h0);
    check("frame_err_pulses", 32'(fe_pulses - f0), (abort && ERR_EN == 1) ? 32'h1 : 32'h0);
    chk_loc = 1'b1;
  endtask

  task automatic peek(input logic [6:0] a, input logic [7:0] exp, input string name);
    chk_loc = 1'b0;
    #2 loc_addr = a;
    #1 check(name, 32'(loc_rdata), 32'(exp));
    @(negedge clock);
    chk_loc = 1'b1;
  endtask

  initial begin
    logic [7:0] rd;
    logic       s;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;

    repeat (3) @(negedge clock);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_wr_valid", 32'(wr_valid), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_loc_rdata", 32'(loc_rdata), 32'h0);
    n_reset = 1'b1;
    repeat (5) @(negedge clock);
    chk_loc = 1'b1;

    frame(8'h10, 8'h55, 16, 0, rd);
    check("wr_addr_after_write", 32'(wr_addr), 32'h10);
    check("wr_data_after_write", 32'(wr_data), 32'h55);
    peek(7'h10, 8'h55, "loc_0x10_written");

    frame(8'h90, 8'h00, 16, 0, rd);
    check("read_0x10", 32'(rd), 32'h55);

    frame(8'h7F, 8'hAA, 16, 0, rd);
    check("wr_data_after_dropped", 32'(wr_data), 32'h55);
    frame(8'hFF, 8'h00, 16, 0, rd);
    check("read_0x7f", 32'(rd), 32'h00);

    frame(8'h1F, 8'hA5, 16, 0, rd);
    frame(8'h9F, 8'hFF, 16, 0, rd);
    check("read_0x1f", 32'(rd), 32'hA5);
    frame(8'h20, 8'h77, 16, 0, rd);
    frame(8'hA0, 8'h00, 16, 0, rd);
    check("read_0x20", 32'(rd), 32'h00);
    check("wr_addr_last_legal", 32'(wr_addr), 32'h1F);

    frame(8'h01, 8'h33, 11, 0, rd);
    peek(7'h01, 8'h00, "loc_0x01_after_abort");
    check("err_cnt_after_abort", 32'(err_cnt), (ERR_EN == 1) ? 32'h1 : 32'h0);

    // Reset in the middle of a write to 0x03, then the frame is abandoned.
    chk_loc = 1'b0;
    @(negedge clock);
    ss = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [15:0] w;
      w = 16'h0344;
      clk_bit(w[15-i], s);
    end
    n_reset = 1'b0;
    ss      = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    exp_err = 0;
    repeat (3) @(negedge clock);
    check("midrst_wr_addr", 32'(wr_addr), 32'h0);
    check("midrst_err_cnt", 32'(err_cnt), 32'h0);
    n_reset = 1'b1;
    repeat (5) @(negedge clock);
    chk_loc = 1'b1;
    peek(7'h10, 8'h00, "loc_0x10_after_reset");

    frame(8'h02, 8'h0F, 16, 0, rd);
    chk_loc = 1'b0;
    for (int a = 0; a < 128; a++) begin
      loc_addr = 7'(a);
      #1 check("bank_scan", 32'(loc_rdata), (a == 2) ? 32'h0F : 32'h00);
    end
    @(negedge clock);
    chk_loc = 1'b1;

    frame(8'h05, 8'h3C, 16, 20, rd);
    check("wr_data_after_extra", 32'(wr_data), 32'h3C);
    frame(8'h85, 8'hFF, 16, 0, rd);
    check("read_0x05", 32'(rd), 32'h3C);
    peek(7'h05, 8'h3C, "loc_0x05_after_read");

    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
